lc3_mem_responder: RTL and testbench
====================================

Name: lc3_mem_responder

Overview:
Memory-side responder for the LC-3 datapath. It accepts read/write requests that the CPU issues from its MAR/MDR (20-bit address, 16-bit write data) and services them from the external asynchronous 16-bit SRAM, applying a programmable number of wait states. A single memory-mapped I/O address is decoded locally: reads return the switch inputs and writes load the hex-display register. It returns read data with a one-cycle ready pulse, the LC-3 "R" signal, that the CPU FSM waits on.

Parameters:
WAIT_STATES, 2, SRAM access cycles per transaction; legal range 1..15.
IO_ADDR, 20'h0FFFF, address decoded as the switch/hex I/O register.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  synchronous, active-low reset.
mem_read  input  1  CPU read request; held until mem_resp is seen.
mem_write  input  1  CPU write request; held until mem_resp is seen.
mem_address  input  20  CPU address (from MAR).
mem_wdata  input  16  CPU write data (from MDR).
mem_rdata  output  16  read data; valid while mem_resp=1.
mem_resp  output  1  one-cycle completion pulse (R).
sram_addr  output  20  SRAM address.
sram_data_in  input  16  data read from the SRAM bus.
sram_data_out  output  16  data driven onto the SRAM bus.
sram_data_oe  output  1  tristate enable for sram_data_out; the top level owns the tristate buffer.
sram_ce_n  output  1  SRAM chip enable, active-low.
sram_oe_n  output  1  SRAM output enable, active-low.
sram_we_n  output  1  SRAM write enable, active-low.
sram_ub_n  output  1  upper byte enable, active-low.
sram_lb_n  output  1  lower byte enable, active-low.
switches  input  16  board switches, read at IO_ADDR.
hex_display  output  16  hex-display register, written at IO_ADDR.

Behaviour:
- FSM states: IDLE, RD_WAIT, WR_WAIT, IO, RESP.
- Reset (reset_n=0 at an edge) forces the following, from any state including mid-transaction:
  - state=IDLE; wait counter=0.
  - mem_resp=0, mem_rdata=0, hex_display=0.
  - sram_addr=0, sram_data_out=0, sram_data_oe=0.
  - All sram_*_n=1.
  - No partial SRAM write is completed; sram_we_n is 1 after the reset edge.
- IDLE:
  - If mem_read or mem_write is sampled, latch mem_address into sram_addr. On a write, also latch mem_wdata into sram_data_out.
  - If both requests are asserted together, the read wins and the write is dropped.
  - If the latched address equals IO_ADDR, go to IO.
  - Otherwise go to RD_WAIT or WR_WAIT and load the counter with WAIT_STATES-1.
- RD_WAIT:
  - sram_ce_n=0, sram_oe_n=0, sram_ub_n=0, sram_lb_n=0, sram_we_n=1, sram_data_oe=0.
  - Decrement the counter each cycle.
  - When counter=0, register sram_data_in into mem_rdata and go to RESP.
- WR_WAIT:
  - sram_ce_n=0, sram_we_n=0, sram_ub_n=0, sram_lb_n=0, sram_oe_n=1, sram_data_oe=1.
  - Decrement the counter; when counter=0, go to RESP.
- IO:
  - Read: mem_rdata <= switches.
  - Write: hex_display <= latched write data.
  - SRAM controls stay inactive. Next state is RESP.
- RESP:
  - mem_resp=1 for exactly one cycle; mem_rdata holds its value. After a write, mem_rdata is unchanged from its previous value.
  - All sram_*_n=1.
  - sram_data_oe stays 1 in this cycle after a write (data hold past the rising edge of we_n), otherwise 0.
  - Next state is IDLE unconditionally.
- Latency, counting from the first cycle a request is sampled in IDLE as cycle 0:
  - SRAM access: mem_resp in cycle WAIT_STATES+1 (cycle 3 at default).
  - IO access: mem_resp in cycle 2.
- Back-to-back requests: a request that is still asserted in the cycle after RESP (state IDLE) is treated as a new transaction.
- Requests, address and data changing mid-transaction are ignored, because all three are latched at acceptance.
- Combinational outputs come only from the state register. There is no combinational path from mem_read/mem_write to any output.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles with mem_read=1 -> mem_resp=0, hex_display=0, sram_ce_n=sram_we_n=sram_oe_n=1, sram_data_oe=0.
- SRAM read: WAIT_STATES=2, mem_address=20'h00123, sram_data_in=16'hBEEF, mem_read held -> sram_addr=20'h00123; ce_n/oe_n low for 2 cycles; mem_resp=1 in cycle 3 with mem_rdata=16'hBEEF; back in IDLE in cycle 4.
- SRAM write: mem_address=20'h00040, mem_wdata=16'h1234, mem_write -> we_n low for exactly 2 cycles with sram_data_out=16'h1234; sram_data_oe=1 through the RESP cycle; mem_resp in cycle 3.
- IO access: write 16'h00A5 to IO_ADDR -> hex_display=16'h00A5 and mem_resp in cycle 2, with no SRAM control toggling. Then read IO_ADDR with switches=16'h3C3C -> mem_rdata=16'h3C3C with mem_resp.
- Simultaneous read and write: mem_read=mem_write=1 at 20'h00010 -> only a read cycle occurs, sram_we_n never low, mem_resp once.
- Reset during WR_WAIT (after 1 cycle of we_n low) -> sram_we_n=1 and sram_data_oe=0 after the reset edge, no mem_resp, and the next read completes normally.

Source files
------------

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder
// Memory-side responder for the LC-3 datapath. Accepts a read or write request
// from the CPU's MAR/MDR, services it from the external asynchronous SRAM with
// a programmable number of wait states, and returns a one-cycle completion
// pulse (the LC-3 "R" signal). A single memory-mapped I/O address is decoded
// locally: reads return the board switches, writes load the hex display.
//
// Ports:
//   clk, reset_n           system clock, synchronous active-low reset
//   mem_read, mem_write    CPU requests, held until mem_resp is seen
//   mem_address            20-bit CPU address (MAR)
//   mem_wdata              16-bit CPU write data (MDR)
//   mem_rdata              read data, valid while mem_resp is high
//   mem_resp               one-cycle completion pulse
//   sram_addr              SRAM address
//   sram_data_in           data read from the SRAM bus
//   sram_data_out          data driven onto the SRAM bus
//   sram_data_oe           tristate enable for sram_data_out (buffer lives at top level)
//   sram_ce_n/oe_n/we_n    SRAM chip/output/write enables, active-low
//   sram_ub_n/lb_n         SRAM byte enables, active-low
//   switches               board switches, read at IO_ADDR
//   hex_display            hex-display register, written at IO_ADDR

module lc3_mem_responder #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [19:0] IO_ADDR     = 20'h0FFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [19:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic [19:0] sram_addr,
    input  logic [15:0] sram_data_in,
    output logic [15:0] sram_data_out,
    output logic        sram_data_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    input  logic [15:0] switches,
    output logic [15:0] hex_display
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        IO,
        RESP
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    state_t     state;
    logic [3:0] wait_count;
    logic       is_write;

    // Single registered FSM. Every output is a flop, and the SRAM strobes are
    // set on the edge that enters a wait state and cleared on the edge that
    // leaves it, so the strobes line up exactly with the wait-state cycles and
    // nothing reaches an output combinationally from the CPU request lines.
    // A write keeps sram_data_oe high through RESP so the bus data is held
    // past the rising edge of sram_we_n.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            wait_count    <= 4'd0;
            is_write      <= 1'b0;
            mem_resp      <= 1'b0;
            mem_rdata     <= 16'h0000;
            hex_display   <= 16'h0000;
            sram_addr     <= 20'h00000;
            sram_data_out <= 16'h0000;
            sram_data_oe  <= 1'b0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_ub_n     <= 1'b1;
            sram_lb_n     <= 1'b1;
        end else begin
            mem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        // Read wins when both are asserted; the write is dropped.
                        sram_addr <= mem_address;
                        is_write  <= !mem_read;
                        if (!mem_read) begin
                            sram_data_out <= mem_wdata;
                        end
                        if (mem_address == IO_ADDR) begin
                            state <= IO;
                        end else if (mem_read) begin
                            state      <= RD_WAIT;
                            wait_count <= WAIT_LOAD;
                            sram_ce_n  <= 1'b0;
                            sram_oe_n  <= 1'b0;
                            sram_ub_n  <= 1'b0;
                            sram_lb_n  <= 1'b0;
                        end else begin
                            state        <= WR_WAIT;
                            wait_count   <= WAIT_LOAD;
                            sram_ce_n    <= 1'b0;
                            sram_we_n    <= 1'b0;
                            sram_ub_n    <= 1'b0;
                            sram_lb_n    <= 1'b0;
                            sram_data_oe <= 1'b1;
                        end
                    end
                end

                RD_WAIT: begin
                    if (wait_count == 4'd0) begin
                        mem_rdata <= sram_data_in;
                        mem_resp  <= 1'b1;
                        state     <= RESP;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                    end else begin
                        wait_count <= wait_count - 4'd1;
                    end
                end

                WR_WAIT: begin
                    if (wait_count == 4'd0) begin
                        mem_resp  <= 1'b1;
                        state     <= RESP;
                        sram_ce_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                    end else begin
                        wait_count <= wait_count - 4'd1;
                    end
                end

                IO: begin
                    if (is_write) begin
                        hex_display <= sram_data_out;
                    end else begin
                        mem_rdata <= switches;
                    end
                    mem_resp <= 1'b1;
                    state    <= RESP;
                end

                RESP: begin
                    sram_data_oe <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder
// Directed self-checking bench for lc3_mem_responder with default parameters
// (WAIT_STATES=2, IO_ADDR=20'h0FFFF). Inputs are driven on the falling edge and
// outputs sampled on the falling edge; cycle 0 is the cycle whose closing rising
// edge first samples a request.

module tb_lc3_mem_responder;

    logic        clk;
    logic        reset_n;
    logic        mem_read;
    logic        mem_write;
    logic [19:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic [19:0] sram_addr;
    logic [15:0] sram_data_in;
    logic [15:0] sram_data_out;
    logic        sram_data_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic [15:0] switches;
    logic [15:0] hex_display;

    int checks = 0;
    int passed = 0;

    // Per-transaction observations gathered by observe()
    int          resp_cycle;
    int          resp_count;
    int          ce_low;
    int          oe_low;
    int          we_low;
    int          doe_high;
    int          last_doe_cycle;
    logic [15:0] rdata_at_resp;
    logic [19:0] addr_c1;
    logic [15:0] dout_c1;

    lc3_mem_responder dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_resp      (mem_resp),
        .sram_addr     (sram_addr),
        .sram_data_in  (sram_data_in),
        .sram_data_out (sram_data_out),
        .sram_data_oe  (sram_data_oe),
        .sram_ce_n     (sram_ce_n),
        .sram_oe_n     (sram_oe_n),
        .sram_we_n     (sram_we_n),
        .sram_ub_n     (sram_ub_n),
        .sram_lb_n     (sram_lb_n),
        .switches      (switches),
        .hex_display   (hex_display)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watches a transaction for a bounded number of cycles, dropping the
    // request as soon as mem_resp is seen, like the CPU would.
    task automatic observe(input int max_cycles);
        resp_cycle     = 0;
        resp_count     = 0;
        ce_low         = 0;
        oe_low         = 0;
        we_low         = 0;
        doe_high       = 0;
        last_doe_cycle = 0;
        rdata_at_resp  = 16'hxxxx;
        for (int c = 1; c <= max_cycles; c++) begin
            @(negedge clk);
            if (c == 1) begin
                addr_c1 = sram_addr;
                dout_c1 = sram_data_out;
            end
            if (!sram_ce_n) ce_low++;
            if (!sram_oe_n) oe_low++;
            if (!sram_we_n) we_low++;
            if (sram_data_oe) begin
                doe_high++;
                last_doe_cycle = c;
            end
            if (mem_resp) begin
                resp_count++;
                if (resp_cycle == 0) resp_cycle = c;
                rdata_at_resp = mem_rdata;
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        mem_read    = 1'b1;
        mem_address = 20'h00123;
        repeat (2) @(negedge clk);
        checks++; if (mem_resp !== 1'b0) $display("[TB] FAIL reset_resp: got %b expected 0", mem_resp); else passed++;
        checks++; if (hex_display !== 16'h0000) $display("[TB] FAIL reset_hex: got %h expected 0000", hex_display); else passed++;
        checks++; if (mem_rdata !== 16'h0000) $display("[TB] FAIL reset_rdata: got %h expected 0000", mem_rdata); else passed++;
        checks++; if ({sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n} !== 5'b11111)
            $display("[TB] FAIL reset_strobes: got %b expected 11111", {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}); else passed++;
        checks++; if (sram_data_oe !== 1'b0) $display("[TB] FAIL reset_data_oe: got %b expected 0", sram_data_oe); else passed++;
        checks++; if (sram_addr !== 20'h00000) $display("[TB] FAIL reset_addr: got %h expected 00000", sram_addr); else passed++;
        mem_read = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sram_read();
        mem_address  = 20'h00123;
        sram_data_in = 16'hBEEF;
        mem_read     = 1'b1;
        observe(6);
        checks++; if (addr_c1 !== 20'h00123) $display("[TB] FAIL rd_addr: got %h expected 00123", addr_c1); else passed++;
        checks++; if (ce_low != 2) $display("[TB] FAIL rd_ce_cycles: got %0d expected 2", ce_low); else passed++;
        checks++; if (oe_low != 2) $display("[TB] FAIL rd_oe_cycles: got %0d expected 2", oe_low); else passed++;
        checks++; if (we_low != 0) $display("[TB] FAIL rd_we_cycles: got %0d expected 0", we_low); else passed++;
        checks++; if (doe_high != 0) $display("[TB] FAIL rd_data_oe: got %0d expected 0", doe_high); else passed++;
        checks++; if (resp_cycle != 3) $display("[TB] FAIL rd_latency: got %0d expected 3", resp_cycle); else passed++;
        checks++; if (resp_count != 1) $display("[TB] FAIL rd_resp_count: got %0d expected 1", resp_count); else passed++;
        checks++; if (rdata_at_resp !== 16'hBEEF) $display("[TB] FAIL rd_data: got %h expected BEEF", rdata_at_resp); else passed++;
    endtask

    task automatic test_sram_write();
        mem_address  = 20'h00040;
        mem_wdata    = 16'h1234;
        sram_data_in = 16'hDEAD;
        mem_write    = 1'b1;
        observe(6);
        checks++; if (addr_c1 !== 20'h00040) $display("[TB] FAIL wr_addr: got %h expected 00040", addr_c1); else passed++;
        checks++; if (dout_c1 !== 16'h1234) $display("[TB] FAIL wr_data_out: got %h expected 1234", dout_c1); else passed++;
        checks++; if (we_low != 2) $display("[TB] FAIL wr_we_cycles: got %0d expected 2", we_low); else passed++;
        checks++; if (oe_low != 0) $display("[TB] FAIL wr_oe_cycles: got %0d expected 0", oe_low); else passed++;
        checks++; if (doe_high != 3 || last_doe_cycle != 3)
            $display("[TB] FAIL wr_data_oe: got %0d cycles ending %0d expected 3 ending 3", doe_high, last_doe_cycle); else passed++;
        checks++; if (resp_cycle != 3) $display("[TB] FAIL wr_latency: got %0d expected 3", resp_cycle); else passed++;
        checks++; if (rdata_at_resp !== 16'hBEEF) $display("[TB] FAIL wr_rdata_kept: got %h expected BEEF", rdata_at_resp); else passed++;
    endtask

    task automatic test_io();
        mem_address = 20'h0FFFF;
        mem_wdata   = 16'h00A5;
        switches    = 16'h3C3C;
        mem_write   = 1'b1;
        observe(5);
        checks++; if (resp_cycle != 2) $display("[TB] FAIL io_wr_latency: got %0d expected 2", resp_cycle); else passed++;
        checks++; if (hex_display !== 16'h00A5) $display("[TB] FAIL io_hex: got %h expected 00A5", hex_display); else passed++;
        checks++; if (ce_low + oe_low + we_low != 0)
            $display("[TB] FAIL io_wr_strobes: got %0d low cycles expected 0", ce_low + oe_low + we_low); else passed++;
        checks++; if (doe_high != 0) $display("[TB] FAIL io_wr_data_oe: got %0d expected 0", doe_high); else passed++;

        mem_read = 1'b1;
        observe(5);
        checks++; if (resp_cycle != 2) $display("[TB] FAIL io_rd_latency: got %0d expected 2", resp_cycle); else passed++;
        checks++; if (rdata_at_resp !== 16'h3C3C) $display("[TB] FAIL io_rd_data: got %h expected 3C3C", rdata_at_resp); else passed++;
        checks++; if (ce_low + oe_low + we_low != 0)
            $display("[TB] FAIL io_rd_strobes: got %0d low cycles expected 0", ce_low + oe_low + we_low); else passed++;
        checks++; if (hex_display !== 16'h00A5) $display("[TB] FAIL io_hex_kept: got %h expected 00A5", hex_display); else passed++;
    endtask

    task automatic test_read_write_together();
        mem_address  = 20'h00010;
        mem_wdata    = 16'hFFFF;
        sram_data_in = 16'h5A5A;
        mem_read     = 1'b1;
        mem_write    = 1'b1;
        observe(6);
        checks++; if (we_low != 0) $display("[TB] FAIL both_we_cycles: got %0d expected 0", we_low); else passed++;
        checks++; if (oe_low != 2) $display("[TB] FAIL both_oe_cycles: got %0d expected 2", oe_low); else passed++;
        checks++; if (resp_count != 1) $display("[TB] FAIL both_resp_count: got %0d expected 1", resp_count); else passed++;
        checks++; if (rdata_at_resp !== 16'h5A5A) $display("[TB] FAIL both_rdata: got %h expected 5A5A", rdata_at_resp); else passed++;
    endtask

    task automatic test_reset_mid_write();
        mem_address = 20'h00200;
        mem_wdata   = 16'h7777;
        mem_write   = 1'b1;
        @(negedge clk);
        checks++; if (sram_we_n !== 1'b0) $display("[TB] FAIL midrst_we_before: got %b expected 0", sram_we_n); else passed++;
        reset_n   = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        checks++; if (sram_we_n !== 1'b1) $display("[TB] FAIL midrst_we_after: got %b expected 1", sram_we_n); else passed++;
        checks++; if (sram_data_oe !== 1'b0) $display("[TB] FAIL midrst_data_oe: got %b expected 0", sram_data_oe); else passed++;
        checks++; if (sram_ce_n !== 1'b1) $display("[TB] FAIL midrst_ce: got %b expected 1", sram_ce_n); else passed++;
        reset_n = 1'b1;
        observe(4);
        checks++; if (resp_count != 0) $display("[TB] FAIL midrst_no_resp: got %0d expected 0", resp_count); else passed++;

        mem_address  = 20'h00300;
        sram_data_in = 16'h0F0F;
        mem_read     = 1'b1;
        observe(6);
        checks++; if (resp_cycle != 3) $display("[TB] FAIL midrst_next_latency: got %0d expected 3", resp_cycle); else passed++;
        checks++; if (rdata_at_resp !== 16'h0F0F) $display("[TB] FAIL midrst_next_data: got %h expected 0F0F", rdata_at_resp); else passed++;
    endtask

    // Test sequence
    initial begin
        reset_n      = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = 20'h00000;
        mem_wdata    = 16'h0000;
        sram_data_in = 16'h0000;
        switches     = 16'h0000;
        @(negedge clk);
        test_reset();
        test_sram_read();
        test_sram_write();
        test_io();
        test_read_write_together();
        test_reset_mid_write();
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
